// File: rtl/tr_baser_link_ctrl.sv
// tr_baser_link_ctrl: 10GBASE-R lane bring-up/recovery sequencer with saturating status counters
module tr_baser_link_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned READY_TIMEOUT = 1048576,
    parameter int unsigned LOCK_STABLE   = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 4194304,
    parameter int unsigned LOSS_TOL      = 64,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk_glbl_i,
    input  logic             rst_glbl_i,
    input  logic             sw_reset_i,
    input  logic             cnt_clr_i,
    input  logic             tx_ready_i,
    input  logic             rx_ready_i,
    input  logic             rx_blk_lock_i,
    output logic             tr_rst_req_o,
    output logic             link_up_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retry_cnt_o,
    output logic [CNT_W-1:0] link_loss_cnt_o
);
    typedef enum logic [2:0] {
        ST_RST        = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_LINK_UP    = 3'd3,
        ST_LOCK_LOST  = 3'd4
    } state_t;

    localparam logic [23:0] RST_LAST    = 24'(RST_CYCLES - 1);
    localparam logic [23:0] READY_LAST  = 24'(READY_TIMEOUT - 1);
    localparam logic [23:0] STABLE_LAST = 24'(LOCK_STABLE - 1);
    localparam logic [23:0] LOCK_LAST   = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] LOSS_LAST   = 24'(LOSS_TOL - 1);

    state_t           state_q, state_d;
    logic [23:0]      timer_q, timer_d;
    logic [23:0]      stab_q, stab_d;
    logic             sync1_q, lock_s_q;
    logic             link_up_q, link_up_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             rdy, inc_retry, inc_loss;

    assign rdy             = tx_ready_i & rx_ready_i;
    assign tr_rst_req_o    = (state_q == ST_RST);
    assign link_up_o       = link_up_q;
    assign state_o         = state_q;
    assign retry_cnt_o     = retry_q;
    assign link_loss_cnt_o = loss_q;

    // bring block lock from the clk_156 domain into clk_glbl
    always_ff @(posedge clk_glbl_i or negedge rst_glbl_i) begin
        if (!rst_glbl_i) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= rx_blk_lock_i;
            lock_s_q <= sync1_q;
        end
    end

    // next state: sw_reset > ready loss > lock event > timeout; illegal codes recover to RST
    always_comb begin
        state_d   = state_q;
        inc_retry = 1'b0;
        inc_loss  = 1'b0;
        if (sw_reset_i) begin
            state_d = ST_RST;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (timer_q == RST_LAST) state_d = ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    if (rdy) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == READY_LAST) begin
                        state_d   = ST_RST;
                        inc_retry = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!rdy) begin
                        state_d   = ST_RST;
                        inc_retry = 1'b1;
                    end else if (lock_s_q && stab_q == STABLE_LAST) begin
                        state_d = ST_LINK_UP;
                    end else if (timer_q == LOCK_LAST) begin
                        state_d   = ST_RST;
                        inc_retry = 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (!rdy) begin
                        state_d  = ST_RST;
                        inc_loss = 1'b1;
                    end else if (!lock_s_q) begin
                        state_d = ST_LOCK_LOST;
                    end
                end
                ST_LOCK_LOST: begin
                    if (!rdy) begin
                        state_d  = ST_RST;
                        inc_loss = 1'b1;
                    end else if (lock_s_q) begin
                        state_d = ST_LINK_UP;
                    end else if (timer_q == LOSS_LAST) begin
                        state_d  = ST_RST;
                        inc_loss = 1'b1;
                    end
                end
                default: state_d = ST_RST;
            endcase
        end
    end

    // timers restart on every state entry (and on sw_reset inside RST); counters saturate, clear wins
    always_comb begin
        timer_d   = (state_d != state_q || sw_reset_i) ? 24'd0 : timer_q + 24'd1;
        stab_d    = (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK && lock_s_q) ? stab_q + 24'd1 : 24'd0;
        link_up_d = (state_d == ST_LINK_UP) || (state_d == ST_LOCK_LOST);
        retry_d   = cnt_clr_i ? '0 : (inc_retry && !(&retry_q)) ? retry_q + 1'b1 : retry_q;
        loss_d    = cnt_clr_i ? '0 : (inc_loss && !(&loss_q)) ? loss_q + 1'b1 : loss_q;
    end

    // sequencer state, timers and status registers
    always_ff @(posedge clk_glbl_i or negedge rst_glbl_i) begin
        if (!rst_glbl_i) begin
            state_q   <= ST_RST;
            timer_q   <= 24'd0;
            stab_q    <= 24'd0;
            link_up_q <= 1'b0;
            retry_q   <= '0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            stab_q    <= stab_d;
            link_up_q <= link_up_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
        end
    end
endmodule

// File: doc/tr_baser_link_ctrl.md
Name: tr_baser_link_ctrl

Overview:
- Link bring-up and recovery sequencer for the 10GBASE-R lane.
- Drives the reset input of the transceiver reset controller and watches its tx/rx ready outputs and the PCS block lock.
- Retries bring-up on timeout and re-initialises the lane after a sustained loss of lock.
- Sits beside the transceiver wrapper in the clk_glbl domain. Exports link_up plus saturating event counters for status registers.

Parameters:
- RST_CYCLES, 16: cycles tr_rst_req is held high per reset attempt (1..2^24-1).
- READY_TIMEOUT, 1048576: max cycles in WAIT_READY before retry.
- LOCK_STABLE, 1024: consecutive cycles of synchronised lock required to declare link up.
- LOCK_TIMEOUT, 4194304: max cycles in WAIT_LOCK before retry.
- LOSS_TOL, 64: cycles lock may be absent in LINK_UP before re-init.
- CNT_W, 8: width of status counters.

Ports:
- clk_glbl  in  1  single clock for all logic.
- rst_glbl  in  1  asynchronous, active-low reset.
- sw_reset  in  1  single-cycle request to re-initialise the lane.
- cnt_clr  in  1  synchronous clear of both counters.
- tx_ready  in  1  transceiver TX ready, clk_glbl domain.
- rx_ready  in  1  transceiver RX ready, clk_glbl domain.
- rx_blk_lock  in  1  PCS block lock, clk_156 domain (asynchronous here).
- tr_rst_req  out  1  reset to transceiver reset controller, active-high.
- link_up  out  1  link established.
- state  out  3  current FSM state.
- retry_cnt  out  CNT_W  failed bring-up attempts, saturating.
- link_loss_cnt  out  CNT_W  link-down events after link_up, saturating.

Behaviour:
- Reset values (rst_glbl low): state=RST(0), tr_rst_req=1, link_up=0, retry_cnt=0, link_loss_cnt=0, all timers 0, sync flops 0.
- rx_blk_lock passes through a 2-FF synchroniser to lock_s (2-cycle latency). tx_ready and rx_ready are used directly; rdy = tx_ready & rx_ready.
- One 24-bit state timer, cleared on every state entry and incremented each cycle in the state. A separate 24-bit stab_cnt counts consecutive lock_s=1 cycles in WAIT_LOCK and clears when lock_s=0.
- States: RST=0, WAIT_READY=1, WAIT_LOCK=2, LINK_UP=3, LOCK_LOST=4. Codes 5-7 are illegal and go to RST.
- RST:
  - tr_rst_req=1.
  - When timer==RST_CYCLES-1, go to WAIT_READY. RST therefore lasts exactly RST_CYCLES cycles.
- WAIT_READY:
  - tr_rst_req=0.
  - rdy=1 → WAIT_LOCK.
  - Otherwise, timer==READY_TIMEOUT-1 → RST, retry_cnt+1.
- WAIT_LOCK:
  - rdy=0 → RST, retry_cnt+1.
  - Otherwise, lock_s=1 and stab_cnt==LOCK_STABLE-1 → LINK_UP.
  - Otherwise, timer==LOCK_TIMEOUT-1 → RST, retry_cnt+1.
- LINK_UP:
  - rdy=0 → RST, link_loss_cnt+1.
  - lock_s=0 → LOCK_LOST.
- LOCK_LOST:
  - rdy=0 → RST, link_loss_cnt+1.
  - lock_s=1 → LINK_UP. Lock return wins over a same-cycle timeout.
  - timer==LOSS_TOL-1 → RST, link_loss_cnt+1.
- link_up is registered: 1 in every cycle where state is LINK_UP or LOCK_LOST, 0 otherwise. It drops the cycle state enters RST.
- sw_reset=1 in any state → RST next cycle. It has highest priority and increments no counter. sw_reset while already in RST restarts the RST timer.
- Priority within a cycle: sw_reset > rdy loss > lock event > timeout.
- Counters:
  - Saturate at 2^CNT_W-1.
  - cnt_clr wins over a same-cycle increment (result 0).
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Sequencing restarts at RST on release.

Test Plan (RST_CYCLES=4, READY_TIMEOUT=32, LOCK_STABLE=8, LOCK_TIMEOUT=64, LOSS_TOL=5):
- Clean bring-up: release rst_glbl, rdy=1, rx_blk_lock=1 → tr_rst_req high 4 cycles, state 1→2. link_up=1 after 8 synced lock cycles. Counters stay 0.
- Ready timeout: rdy held 0 → return to RST after 32 cycles in WAIT_READY. retry_cnt increments 1,2,3 across three attempts, saturating at 255 after 255 attempts.
- Lock glitch: in LINK_UP, drop rx_blk_lock for 3 cycles → state 4 then back to 3. link_up stays 1, link_loss_cnt=0.
- Lock loss: in LINK_UP, drop rx_blk_lock permanently → 5 cycles in LOCK_LOST, then RST, link_up=0, link_loss_cnt=1.
- Priority and clear:
  - sw_reset in the same cycle as tx_ready falls in LINK_UP → RST with link_loss_cnt unchanged.
  - cnt_clr coincident with a retry increment → retry_cnt=0.
- Asynchronous reset in WAIT_LOCK at a mid-clock instant → tr_rst_req=1, state=0 without waiting for a clock edge. After release, tr_rst_req is held for exactly 4 cycles.
